// File: rtl/sgpr_wr_port_arbiter_pkg.sv
// Shared SGPR write-port widths, requester indices and small helpers used by the
// write-port arbiter and its round-robin sub-block.
package sgpr_wr_port_arbiter_pkg;

    localparam int unsigned SGPR_WR_EN_W = 4;
    localparam int unsigned SGPR_ADDR_W  = 9;
    localparam int unsigned SGPR_DATA_W  = 128;

    localparam int unsigned MAX_PORTS  = 16;
    localparam int unsigned GRANT_ID_W = 4;
    localparam int unsigned STALL_W    = 16;

    // Requester slots on the SGPR write port.
    typedef enum logic [GRANT_ID_W-1:0] {
        PortSimd0 = 4'd0,
        PortSimd1 = 4'd1,
        PortSimd2 = 4'd2,
        PortSimd3 = 4'd3,
        PortSimf0 = 4'd4,
        PortSimf1 = 4'd5,
        PortSimf2 = 4'd6,
        PortSimf3 = 4'd7,
        PortLsu   = 4'd8,
        PortSalu  = 4'd9
    } wr_port_e;

    // True when two or more bits are set (clearing the lowest set bit leaves something).
    function automatic logic more_than_one(input logic [MAX_PORTS-1:0] v);
        return (v & (v - 16'd1)) != '0;
    endfunction

endpackage

// File: rtl/sgpr_wr_port_arbiter_rr_arbiter.sv
// One-hot arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
// The wrap-around search is a priority encoder over {req, req & bits-at-or-above-ptr}.
module sgpr_wr_port_arbiter_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 10,
    parameter bit          RR_MODE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PtrW-1:0]        ptr_q;
    logic [PtrW-1:0]        grant_idx;
    logic [NUM_PORTS-1:0]   ptr_mask;
    logic [2*NUM_PORTS-1:0] req_dbl;
    logic                   found;

    always_comb begin
        ptr_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ptr_mask[i] = (i >= int'(ptr_q));
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        req_dbl   = {req, req & ptr_mask};
        for (int i = 0; i < 2 * NUM_PORTS; i++) begin
            if (!found && req_dbl[i]) begin
                found                 = 1'b1;
                grant_idx             = PtrW'(i % NUM_PORTS);
                grant[i % NUM_PORTS]  = 1'b1;
            end
        end
    end

    if (RR_MODE) begin : g_rr
        logic [PtrW-1:0] ptr_d;

        always_comb begin
            ptr_d = ptr_q;
            if (advance) begin
                ptr_d = (grant_idx == PtrW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_fixed
        // Fixed priority: the pointer is pinned at 0 so the low half alone decides.
        logic unused_fixed;
        assign unused_fixed = ^{clk, rst, advance, grant_idx};
        assign ptr_q        = '0;
    end

endmodule

// File: rtl/sgpr_wr_port_arbiter.sv
// SGPR write-port arbiter: grants one of NUM_PORTS valid/ready requesters per cycle and
// registers the winner's write onto the single SGPR bank write port.
module sgpr_wr_port_arbiter
    import sgpr_wr_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 10,
    parameter int unsigned EN_W      = SGPR_WR_EN_W,
    parameter int unsigned ADDR_W    = SGPR_ADDR_W,
    parameter int unsigned DATA_W    = SGPR_DATA_W,
    parameter bit          RR_MODE   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*EN_W-1:0]     req_wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wr_data,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wr_mask,
    output logic [EN_W-1:0]               muxed_port_wr_en,
    output logic [ADDR_W-1:0]             muxed_port_wr_addr,
    output logic [DATA_W-1:0]             muxed_port_wr_data,
    output logic [DATA_W-1:0]             muxed_port_wr_mask,
    output logic [GRANT_ID_W-1:0]         grant_id,
    output logic [STALL_W-1:0]            stall_cnt
);

    if (NUM_PORTS > MAX_PORTS || NUM_PORTS < 2) begin : g_bad_num_ports
        $error("sgpr_wr_port_arbiter: NUM_PORTS must be in 2..16");
    end

    logic [NUM_PORTS-1:0]  grant;
    logic                  advance;
    logic                  multi_valid;

    sgpr_wr_port_arbiter_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .RR_MODE   (RR_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    // No grant may be issued in a reset cycle; gating here also freezes the pointer.
    assign req_ready   = rst ? '0 : grant;
    assign advance     = |req_ready;
    assign multi_valid = more_than_one(16'(req_valid));

    logic [EN_W-1:0]       sel_en;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [DATA_W-1:0]     sel_mask;
    logic [GRANT_ID_W-1:0] sel_id;

    // AND-OR mux keyed by the one-hot ready vector.
    always_comb begin
        sel_en   = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_mask = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ready[i]) begin
                sel_en   |= req_wr_en[i*EN_W +: EN_W];
                sel_addr |= req_wr_addr[i*ADDR_W +: ADDR_W];
                sel_data |= req_wr_data[i*DATA_W +: DATA_W];
                sel_mask |= req_wr_mask[i*DATA_W +: DATA_W];
                sel_id   |= GRANT_ID_W'(i);
            end
        end
    end

    logic [EN_W-1:0]       en_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     mask_q;
    logic [GRANT_ID_W-1:0] id_q;
    logic [STALL_W-1:0]    stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            stall_q <= '0;
        end else begin
            en_q <= advance ? sel_en : '0;
            if (advance) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
                mask_q <= sel_mask;
                id_q   <= sel_id;
            end
            if (multi_valid && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign muxed_port_wr_en   = en_q;
    assign muxed_port_wr_addr = addr_q;
    assign muxed_port_wr_data = data_q;
    assign muxed_port_wr_mask = mask_q;
    assign grant_id           = id_q;
    assign stall_cnt          = stall_q;

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
// Self-checking bench for sgpr_wr_port_arbiter: directed scenarios plus a randomized
// requester population checked against a queue-free behavioural arbitration model.
module tb_sgpr_wr_port_arbiter;

    localparam int N  = 10;
    localparam int EW = 4;
    localparam int AW = 9;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid    = '0;
    logic [N-1:0]    req_valid_fp = '0;
    logic [N-1:0]    req_ready, req_ready_fp;
    logic [EW-1:0]   en_a   [N];
    logic [AW-1:0]   addr_a [N];
    logic [DW-1:0]   data_a [N];
    logic [DW-1:0]   mask_a [N];
    logic [N*EW-1:0] req_wr_en;
    logic [N*AW-1:0] req_wr_addr;
    logic [N*DW-1:0] req_wr_data, req_wr_mask;

    always_comb begin
        req_wr_en = '0; req_wr_addr = '0; req_wr_data = '0; req_wr_mask = '0;
        for (int i = 0; i < N; i++) begin
            req_wr_en[i*EW +: EW]   = en_a[i];
            req_wr_addr[i*AW +: AW] = addr_a[i];
            req_wr_data[i*DW +: DW] = data_a[i];
            req_wr_mask[i*DW +: DW] = mask_a[i];
        end
    end

    logic [EW-1:0] o_en, o_en_fp;
    logic [AW-1:0] o_addr, o_addr_fp;
    logic [DW-1:0] o_data, o_mask, o_data_fp, o_mask_fp;
    logic [3:0]    o_gid, o_gid_fp;
    logic [15:0]   o_stall, o_stall_fp;

    sgpr_wr_port_arbiter #(.NUM_PORTS(N), .EN_W(EW), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
        .req_wr_mask(req_wr_mask), .muxed_port_wr_en(o_en), .muxed_port_wr_addr(o_addr),
        .muxed_port_wr_data(o_data), .muxed_port_wr_mask(o_mask), .grant_id(o_gid),
        .stall_cnt(o_stall)
    );

    sgpr_wr_port_arbiter #(.NUM_PORTS(N), .EN_W(EW), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid_fp), .req_ready(req_ready_fp),
        .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
        .req_wr_mask(req_wr_mask), .muxed_port_wr_en(o_en_fp), .muxed_port_wr_addr(o_addr_fp),
        .muxed_port_wr_data(o_data_fp), .muxed_port_wr_mask(o_mask_fp), .grant_id(o_gid_fp),
        .stall_cnt(o_stall_fp)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the round-robin DUT.
    int            m_ptr = 0;
    logic [EW-1:0] m_en = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_mask = '0;
    logic [3:0]    m_gid = '0;
    int            m_stall = 0;
    int            last_grant = -1;

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst) return r;
        g = pick(req_valid, m_ptr);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int g;
        int pc;
        g  = rst ? -1 : pick(req_valid, m_ptr);
        pc = $countones(req_valid);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_en = '0; m_addr = '0; m_data = '0; m_mask = '0; m_gid = '0; m_stall = 0;
        end else begin
            if (pc > 1 && m_stall < 65535) m_stall++;
            if (g >= 0) begin
                m_en = en_a[g]; m_addr = addr_a[g]; m_data = data_a[g]; m_mask = mask_a[g];
                m_gid = 4'(g);
                m_ptr = (g + 1) % N;
            end else begin
                m_en = '0;
            end
        end
        last_grant = g;
        #1;
    endtask

    task automatic set_payload(input int p);
        en_a[p]   = 4'($urandom_range(0, 15));
        addr_a[p] = 9'($urandom);
        data_a[p] = {$urandom, $urandom, $urandom, $urandom};
        mask_a[p] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        for (int p = 0; p < N; p++) set_payload(p);
        rst = 1'b1;
        req_valid = '1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        tick();
        tick();
        vectors++;
        if ({o_en, o_addr, o_data, o_mask, o_gid, o_stall} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%h addr=%h gid=%0d stall=%0d want all 0",
                     o_en, o_addr, o_gid, o_stall);
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_fixed_prio();
        req_valid_fp = '0;
        req_valid_fp[2] = 1'b1;
        req_valid_fp[7] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (req_ready_fp !== 10'b00_0000_0100) begin
                miscompares++; $display("FAIL fp_ready: got %b want 0000000100", req_ready_fp);
            end
            tick();
            vectors++;
            if (o_gid_fp !== 4'd2 || o_en_fp !== en_a[2] || o_addr_fp !== addr_a[2]) begin
                miscompares++;
                $display("FAIL fp_out: gid=%0d en=%h addr=%h want gid=2 en=%h addr=%h",
                         o_gid_fp, o_en_fp, o_addr_fp, en_a[2], addr_a[2]);
            end
        end
        vectors++;
        if (o_stall_fp !== 16'd5) begin
            miscompares++; $display("FAIL fp_stall: got %0d want 5", o_stall_fp);
        end
        req_valid_fp[2] = 1'b0;
        #1;
        vectors++;
        if (req_ready_fp !== 10'b00_1000_0000) begin
            miscompares++; $display("FAIL fp_ready7: got %b want 0010000000", req_ready_fp);
        end
        tick();
        vectors++;
        if (o_gid_fp !== 4'd7) begin
            miscompares++; $display("FAIL fp_gid7: got %0d want 7", o_gid_fp);
        end
        req_valid_fp = '0;
    endtask

    task automatic test_single();
        addr_a[3] = 9'h012;
        data_a[3] = {16{8'hA5}};
        en_a[3]   = 4'hF;
        mask_a[3] = '1;
        req_valid = 10'b00_0000_1000;
        #1;
        vectors++;
        if (req_ready !== 10'b00_0000_1000) begin
            miscompares++; $display("FAIL single_ready: got %b want 0000001000", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (o_en !== 4'hF || o_addr !== 9'h012 || o_gid !== 4'd3 ||
            o_data !== {16{8'hA5}} || o_mask !== {DW{1'b1}}) begin
            miscompares++;
            $display("FAIL single_out: en=%h addr=%h gid=%0d want en=f addr=012 gid=3",
                     o_en, o_addr, o_gid);
        end
    endtask

    task automatic test_idle_hold();
        set_payload(6);
        addr_a[6] = 9'h1FF;
        req_valid = 10'b00_0100_0000;
        tick();
        req_valid = '0;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL idle_ready: got %b want 0", req_ready);
        end
        tick();
        vectors++;
        if (o_en !== 4'h0 || o_addr !== 9'h1FF || o_gid !== 4'd6 || o_data !== data_a[6]) begin
            miscompares++;
            $display("FAIL idle_hold: en=%h addr=%h gid=%0d want en=0 addr=1ff gid=6",
                     o_en, o_addr, o_gid);
        end
        vectors++;
        if ($isunknown({o_en, o_addr, o_data, o_mask, o_gid, o_stall}) !== 1'b0) begin
            miscompares++; $display("FAIL idle_x: outputs carry X/Z, want none");
        end
    endtask

    task automatic test_all_ports();
        int served [N];
        req_valid = 10'b00_0001_0000;
        tick();
        rst = 1'b1;
        req_valid = '1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < N; p++) served[p] = 0;
        for (int k = 0; k <= N; k++) begin
            logic [N-1:0] want;
            want = '0;
            want[k % N] = 1'b1;
            #1;
            vectors++;
            if (req_ready !== want) begin
                miscompares++; $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, want);
            end
            tick();
            vectors++;
            if (o_gid !== 4'(k % N) || o_en !== en_a[k % N]) begin
                miscompares++;
                $display("FAIL rr_gid_%0d: got %0d want %0d", k, o_gid, k % N);
            end
            if (k < N) served[o_gid]++;
            if (k == N - 1) begin
                vectors++;
                if (o_stall !== 16'd10) begin
                    miscompares++; $display("FAIL rr_stall: got %0d want 10", o_stall);
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            vectors++;
            if (served[p] !== 1) begin
                miscompares++; $display("FAIL rr_fair_%0d: served %0d want 1", p, served[p]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 10'b01_0000_0000;
        tick();
        req_valid = 10'b10_0000_0001;
        #1;
        vectors++;
        if (req_ready !== 10'b10_0000_0000) begin
            miscompares++; $display("FAIL wrap_ready9: got %b want 1000000000", req_ready);
        end
        tick();
        req_valid[9] = 1'b0;
        vectors++;
        if (o_gid !== 4'd9) begin
            miscompares++; $display("FAIL wrap_gid9: got %0d want 9", o_gid);
        end
        tick();
        req_valid[0] = 1'b0;
        vectors++;
        if (o_gid !== 4'd0) begin
            miscompares++; $display("FAIL wrap_gid0: got %0d want 0", o_gid);
        end
        // Pointer now at 1, so port 1 beats port 0.
        set_payload(0);
        set_payload(1);
        req_valid = 10'b00_0000_0011;
        #1;
        vectors++;
        if (req_ready !== 10'b00_0000_0010) begin
            miscompares++; $display("FAIL wrap_ptr1: got %b want 0000000010", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        set_payload(5);
        req_valid = 10'b00_0000_0100;
        tick();
        req_valid = 10'b00_0010_0000;
        #1;
        vectors++;
        if (req_ready !== 10'b00_0010_0000) begin
            miscompares++; $display("FAIL mid_pre_ready: got %b want 0000100000", req_ready);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL mid_rst_ready: got %b want 0", req_ready);
        end
        tick();
        rst = 1'b0;
        vectors++;
        if (o_en !== 4'h0 || o_gid !== 4'd0) begin
            miscompares++; $display("FAIL mid_rst_out: en=%h gid=%0d want 0/0", o_en, o_gid);
        end
        #1;
        vectors++;
        if (req_ready !== 10'b00_0010_0000) begin
            miscompares++; $display("FAIL mid_post_ready: got %b want 0000100000", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (o_gid !== 4'd5 || o_en !== en_a[5] || o_addr !== addr_a[5]) begin
            miscompares++;
            $display("FAIL mid_post_out: gid=%0d en=%h want gid=5 en=%h", o_gid, o_en, en_a[5]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] want;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
                    set_payload(p);
                    req_valid[p] = 1'b1;
                end
            end
            #1;
            want = model_ready();
            vectors++;
            if (req_ready !== want) begin
                miscompares++; $display("FAIL rand_ready_%0d: got %b want %b", c, req_ready, want);
            end
            tick();
            vectors++;
            if (o_en !== m_en || o_addr !== m_addr || o_data !== m_data || o_mask !== m_mask ||
                o_gid !== m_gid || o_stall !== 16'(m_stall)) begin
                miscompares++;
                $display("FAIL rand_out_%0d: en=%h addr=%h gid=%0d stall=%0d want %h %h %0d %0d",
                         c, o_en, o_addr, o_gid, o_stall, m_en, m_addr, m_gid, m_stall);
            end
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_single();
        test_idle_hold();
        test_all_ports();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sgpr_wr_port_arbiter.md
Name: sgpr_wr_port_arbiter

Overview:
Parametrised successor to the one-hot SGPR write-port select mux. It arbitrates between NUM_PORTS independent write requesters (SALU, SIMD/SIMF, LSU, ...) using a valid/ready handshake, so simultaneous requests stall instead of producing X. The granted request drives a single registered SGPR write port. It sits between the functional-unit write-back paths and the SGPR bank write port, replacing the externally-driven wr_port_select.

Parameters:
NUM_PORTS, 10, number of requester ports (2..16)
EN_W, 4, width of the write-enable field per request
ADDR_W, 9, SGPR address width
DATA_W, 128, write data and write mask width
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_PORTS  per-port request valid
req_ready  output  NUM_PORTS  per-port grant/accept, combinational from req_valid and arbiter state
req_wr_en  input  NUM_PORTS*EN_W  packed per-port enables; port i occupies bits [i*EN_W +: EN_W]
req_wr_addr  input  NUM_PORTS*ADDR_W  packed per-port addresses
req_wr_data  input  NUM_PORTS*DATA_W  packed per-port data
req_wr_mask  input  NUM_PORTS*DATA_W  packed per-port masks
muxed_port_wr_en  output  EN_W  registered write enable to the SGPR bank
muxed_port_wr_addr  output  ADDR_W  registered address
muxed_port_wr_data  output  DATA_W  registered data
muxed_port_wr_mask  output  DATA_W  registered mask
grant_id  output  4  registered index of the port currently driving the outputs
stall_cnt  output  16  saturating count of cycles with more than one valid request

Behaviour:
- Reset values: muxed_port_wr_en = 0; addr/data/mask = 0; grant_id = 0; stall_cnt = 0; rr_ptr = 0; req_ready = 0 during the reset cycle.
- Handshake: a transfer occurs on port i when req_valid[i] and req_ready[i] are both 1 at a rising edge.
  - A requester holds valid and payload stable until it receives ready; payload changes while waiting are illegal.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] is never high when req_valid[i] = 0.
- Arbitration:
  - RR_MODE = 1: search starts at rr_ptr and wraps modulo NUM_PORTS; the first valid port wins. After a grant to port g, rr_ptr = (g+1) mod NUM_PORTS, with wrap from NUM_PORTS-1 to 0. rr_ptr is unchanged when there is no grant.
  - RR_MODE = 0: lowest valid index wins; no pointer.
- Latency: exactly 1 cycle. A grant in cycle N drives the muxed outputs and grant_id in cycle N+1. Throughput is one write per cycle; no bubbles when requests are back-to-back.
- No grant in cycle N: muxed_port_wr_en = 0 in cycle N+1. addr/data/mask hold their previous values (no X), and grant_id holds.
- A granted request whose req_wr_en = 0 is still accepted and forwarded with en = 0.
- stall_cnt increments when popcount(req_valid) > 1 and saturates at 16'hFFFF.
- rst asserted mid-operation: the in-flight output register is cleared (en = 0 in the next cycle), rr_ptr returns to 0, and no grant is issued that cycle. Requesters keep valid asserted and are re-arbitrated after reset.
- NUM_PORTS > 16 is illegal; an elaboration-time check flags it.

Decomposition:
- Shared package (define include beside global_definitions.v):
  - SGPR_WR_EN_W = 4, SGPR_ADDR_W = 9, SGPR_DATA_W = 128.
  - Port index constants naming each requester, with SALU at index 9.
- Sub-module rr_arbiter(NUM_PORTS, RR_MODE):
  - Inputs: clk, rst, req, advance.
  - Output: one-hot grant.
  - Uses a double-width masked priority encoder for the wrap.
- The top level does the packed-vector slicing, the output register and stall_cnt.

Test Plan:
- Single request: port 3 valid with addr 9'h012, data 128'hA5..A5, en 4'hF, mask all-ones -> ready[3] = 1 in the same cycle; in the next cycle muxed en = 4'hF, addr = 9'h012, grant_id = 3.
- All 10 ports valid continuously, RR_MODE = 1, starting from reset -> grant order 0,1,...,9,0; each port served once in any 10 cycles; stall_cnt = 10 after 10 cycles.
- RR_MODE = 0 with ports 2 and 7 valid -> port 2 is granted every cycle; port 7 is never ready while port 2 stays valid.
- Ports 9 and 0 valid with rr_ptr = 9 -> 9 is granted, then 0 (wrap), then rr_ptr = 1.
- Idle cycle after a write to addr 9'h1FF -> muxed en = 0, addr holds 9'h1FF, no X on any output.
- rst pulsed for 1 cycle while port 5 is being granted -> next-cycle en = 0, rr_ptr = 0; port 5, still valid, is granted on the first cycle after reset.
